lcu_cmp_arbiter: RTL and testbench
==================================

# lcu_cmp_arbiter

Round-robin arbiter that shares one WIDTH-bit carry-chain magnitude comparator between NREQ requesters. Each requester submits an operand pair (a, b) with a valid/ready handshake. The block returns a tagged response carrying the requester ID and the full flag set: unsigned and signed gt/lt/ge/le, plus zero and max on operand a. It sits between the lcu datapath (the CARRY4-chain compare/zero/max logic) and the client logic that previously needed one comparator per client.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 32: operand width, 4..64.
- `IDW`, 3: width of the response ID field; must satisfy 2^IDW >= NREQ.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NREQ: per-requester request valid.
- `req_ready`  out  NREQ: per-requester accept; at most one bit high per cycle.
- `req_a`  in  NREQ*WIDTH: operand a, requester i at bits [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH: operand b, same packing as `req_a`.
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: response consumer ready.
- `rsp_id`  out  IDW: index of the requester that issued the response.
- `rsp_flags`  out  10: {max, zero, les, leu, ges, geu, lts, ltu, gts, gtu}.

## Operation
- Transfer rule: a request or response transfers on a rising edge where its valid and ready are both high.
- Requester obligations: once `req_valid[i]` rises, requester i holds it and its operands stable until accepted.
- Round-robin pointer `ptr`: after reset it is 0. Grant goes to the first i with `req_valid[i]`=1, searching i = ptr, ptr+1, … mod NREQ.
- Pointer update: after each accepted request from i, `ptr` becomes (i+1) mod NREQ. With no acceptance, `ptr` holds.
- `req_ready[grant]` is combinational from `req_valid`, `ptr` and `can_accept`. All other ready bits are 0. `req_ready` never depends on `rsp_ready` other than through `can_accept`.
- Output register:
  - `can_accept` = !out_valid || rsp_ready when CMP_ARB_PIPE_EN is undefined.
  - With CMP_ARB_PIPE_EN defined, `can_accept` is the stage-1 rule given under Configuration.
- Flags, with a, b from the accepted request:
  - gtu = a>b unsigned; ltu = a<b unsigned; geu = !ltu; leu = !gtu.
  - gts, lts, ges, les are the same comparisons on two's-complement operands.
  - zero = (a==0); max = (a=={WIDTH{1'b1}}).
- Datapath rules:
  - All comparisons use one shared WIDTH+1-bit subtraction a-b. The unsigned borrow gives ltu.
  - Signed result: lts = sign(a-b) XOR overflow. Equality comes from the zero-detect of the difference.
  - No other adders or comparators exist in the datapath.
- Backpressure: while `rsp_valid`=1 and `rsp_ready`=0, `rsp_id` and `rsp_flags` stay bit-stable and no new request is accepted.
- Simultaneous events: a response consumed and a new request accepted on the same edge is legal and yields back-to-back responses at full throughput (one per cycle).
- Reset mid-operation: in-flight requests and responses are discarded with no replay. Requesters must re-present.

## Timing
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_flags`=0, `ptr`=0, all pipeline valids 0. `req_ready`=0 in the cycle `rst` is high.
- Latency without CMP_ARB_PIPE_EN: request accepted at edge t gives `rsp_valid`=1 after edge t (visible in cycle t+1).
- Latency with CMP_ARB_PIPE_EN: response visible in cycle t+2.
- Throughput: one compare per cycle in both modes when `rsp_ready`=1.
- Requester starvation bound: a request held valid is accepted within NREQ accepting cycles.

## Configuration
- Macro `CMP_ARB_PIPE_EN`.
- Defined: adds stage-1 registers for the operands and ID between the grant and the subtractor. The long carry chain then starts from a flop and ends at the output register.
  - Stage 1 advances when the output register is empty or being consumed.
  - `can_accept` = !s1_valid || s1_advance.
  - Latency is 2 cycles.
- Undefined: the grant mux feeds the subtractor directly. Latency is 1 cycle.
- Flag values, ordering and arbitration are identical in both modes.

## Test plan
- Zero and max flags: requester 0 sends a=0, b=0, then a=0xFFFFFFFF, b=0.
  - First response: zero=1, max=0, geu=leu=ges=les=1, all gt/lt flags 0.
  - Second response: max=1, zero=0, gtu=1, geu=1, lts=1, les=1 (a is −1 signed), gts=0, ltu=0.
- Signed vs unsigned split: requester 2 sends a=0x80000000, b=0x7FFFFFFF.
  - Response: rsp_id=2, gtu=1, geu=1, ltu=0, gts=0, lts=1, les=1.
  - Check the response appears in cycle t+1 without the macro and t+2 with it.
- Fairness: all 4 requesters are valid every cycle from reset with `rsp_ready`=1.
  - Accepts go 0,1,2,3,0,1,… with one response per cycle.
  - Requester 1 dropping valid for one cycle causes it to be skipped without stalling.
- Backpressure: hold `rsp_ready`=0 for 5 cycles while requesters 0 and 3 are valid.
  - `rsp_*` stays stable and `req_ready`=0 throughout.
  - On release, the responses drain in round-robin order with no loss or duplication.
- Reset mid-stream: assert `rst` for 1 cycle with a response pending and another request in flight.
  - Next cycle: `rsp_valid`=0, `ptr`=0, and the next grant goes to the lowest-index valid requester.
- Sweep: a counter-vs-threshold sweep modelled on the lcu bench, with a=counter and b=counter−31 ± k for k=0..63 over 10,000 requests.
  - Every flag matches the reference unsigned and signed comparisons.

Source files
------------

// File: rtl/lcu_cmp_arbiter.sv
// Round-robin arbiter sharing one WIDTH+1-bit subtract-based magnitude comparator among NREQ requesters.
// Optional macro CMP_ARB_PIPE_EN registers operands/ID ahead of the subtractor (2-cycle latency).
module lcu_cmp_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [9:0]            rsp_flags
);

  function automatic logic [IDW-1:0] first_set(input logic [NREQ-1:0] mask);
    logic [IDW-1:0] idx;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = IDW'(i);
      end
    end
    return idx;
  endfunction

  // Every flag derives from one shared subtraction: borrow, sign, overflow and zero-detect.
  function automatic logic [9:0] cmp_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] diff;
    logic           ltu;
    logic           lts;
    logic           eq;
    logic           ovf;
    logic           gtu;
    logic           gts;
    diff = {1'b0, a} - {1'b0, b};
    ltu  = diff[WIDTH];
    eq   = ~|diff[WIDTH-1:0];
    ovf  = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]);
    lts  = diff[WIDTH-1] ^ ovf;
    gtu  = ~ltu & ~eq;
    gts  = ~lts & ~eq;
    return {&a, ~|a, ~gts, ~gtu, ~lts, ~ltu, lts, ltu, gts, gtu};
  endfunction

  logic [IDW-1:0]   ptr_r;
  logic [NREQ-1:0]  upper_mask_s;
  logic [IDW-1:0]   grant_s;
  logic             any_valid_s;
  logic             can_accept_s;
  logic             accept_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic             out_valid_r;

  assign rsp_valid = out_valid_r;

  // Rotating priority: requesters at or above ptr win first, otherwise wrap to the lowest index.
  always_comb begin
    upper_mask_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      upper_mask_s[i] = req_valid[i] & (IDW'(i) >= ptr_r);
    end
    any_valid_s = |req_valid;
    if (|upper_mask_s) begin
      grant_s = first_set(upper_mask_s);
    end else begin
      grant_s = first_set(req_valid);
    end
  end

  // One-hot ready on the granted requester; all zero in reset or while no slot is free.
  always_comb begin
    req_ready = '0;
    accept_s  = 1'b0;
    if (!rst && any_valid_s && can_accept_s) begin
      accept_s = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        req_ready[i] = (grant_s == IDW'(i));
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  // Grant mux: AND-OR select of the granted operand pair.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_a_s = sel_a_s | (req_a[i*WIDTH +: WIDTH] & {WIDTH{grant_s == IDW'(i)}});
      sel_b_s = sel_b_s | (req_b[i*WIDTH +: WIDTH] & {WIDTH{grant_s == IDW'(i)}});
    end
  end

  // Pointer moves just past the accepted requester and holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (accept_s) begin
      ptr_r <= (grant_s == IDW'(NREQ - 1)) ? '0 : grant_s + IDW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

`ifdef CMP_ARB_PIPE_EN
  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [IDW-1:0]   s1_id_r;
  logic             s1_advance_s;

  assign s1_advance_s = s1_valid_r & (~out_valid_r | rsp_ready);
  assign can_accept_s = ~s1_valid_r | s1_advance_s;

  // Stage 1 captures the granted pair so the carry chain starts from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= '0;
      s1_b_r     <= '0;
      s1_id_r    <= '0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_a_r     <= sel_a_s;
      s1_b_r     <= sel_b_s;
      s1_id_r    <= grant_s;
    end else if (s1_advance_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Output register loads from stage 1 and stays bit-stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      rsp_id      <= '0;
      rsp_flags   <= '0;
    end else if (s1_advance_s) begin
      out_valid_r <= 1'b1;
      rsp_id      <= s1_id_r;
      rsp_flags   <= cmp_flags(s1_a_r, s1_b_r);
    end else if (rsp_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end
`else
  assign can_accept_s = ~out_valid_r | rsp_ready;

  // Output register loads straight from the grant mux and stays bit-stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      rsp_id      <= '0;
      rsp_flags   <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      rsp_id      <= grant_s;
      rsp_flags   <= cmp_flags(sel_a_s, sel_b_s);
    end else if (rsp_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end
`endif

endmodule

// File: tb/tb_lcu_cmp_arbiter.sv
// Directed bench for lcu_cmp_arbiter: flags, latency, fairness, backpressure, reset and a compare sweep.
module tb_lcu_cmp_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 3;
`ifdef CMP_ARB_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [9:0]            rsp_flags;

  int errors = 0;
  int checks = 0;
  logic [12:0] got_q[$];
  logic [12:0] exp_q[$];
  logic [NREQ-1:0] acc;

  int          fair_grant [13] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0, 1};
  logic [3:0]  fair_mask  [13] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                                   4'hF, 4'hD, 4'hF, 4'hF, 4'hF};
  logic [9:0]  fair_flags [4]  = '{10'h1CC, 10'h0CC, 10'h0F0, 10'h033};
  logic [31:0] sweep_base [4]  = '{32'h0000_0000, 32'h7FFF_FFC0, 32'h8000_0010, 32'hFFFF_FFC0};
  int          rid;
  logic [31:0] cnt;
  logic [31:0] op_a;
  logic [31:0] op_b;

  always #5 clk = ~clk;

  lcu_cmp_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_flags(rsp_flags)
  );

  // Response monitor: inputs only change just after posedge, so negedge sees what transfers next edge.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) got_q.push_back({rsp_id, rsp_flags});
  end

  function automatic logic [9:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    return {(a == 32'hFFFF_FFFF), (a == 32'd0), (sa <= sb), (a <= b), (sa >= sb), (a >= b),
            (sa < sb), (a < b), (sa > sb), (a > b)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic expect_rsp(input int id, input logic [9:0] f);
    exp_q.push_back({3'(id), f});
  endtask

  // Each requester drops valid after the edge on which it was granted.
  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      #1;
      acc = req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc;
    end
  endtask

  task automatic send(input int i, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    set_req(i, a, b);
    req_valid[i] = 1'b1;
    #1;
    while (!req_ready[i] && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("send_grant", req_ready[i], 64'd1);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 400) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) check(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    rst       = 1'b1;
    tick();
    tick();
    check("rst_ready", req_ready, 64'd0);
    check("rst_rsp_valid", rsp_valid, 64'd0);
    check("rst_rsp_id", rsp_id, 64'd0);
    check("rst_rsp_flags", rsp_flags, 64'd0);
    rst       = 1'b0;
    req_valid = '0;
    tick();

    // zero / max / equal vectors
    send(0, 32'h0000_0000, 32'h0000_0000);
    expect_rsp(0, 10'h1F0);
    send(0, 32'hFFFF_FFFF, 32'h0000_0000);
    expect_rsp(0, 10'h299);
    send(1, 32'd5, 32'd5);
    expect_rsp(1, 10'h0F0);
    drain("zero_max");

    // signed/unsigned split, latency observed with the response held
    rsp_ready = 1'b0;
    set_req(2, 32'h8000_0000, 32'h7FFF_FFFF);
    req_valid = 4'b0100;
    #1;
    check("split_ready", req_ready, 64'h4);
    @(posedge clk);
    #1;
    req_valid = '0;
    check("split_t1_valid", rsp_valid, (LAT == 1) ? 64'd1 : 64'd0);
    tick();
    check("split_t2_valid", rsp_valid, 64'd1);
    check("split_id", rsp_id, 64'd2);
    check("split_flags", rsp_flags, 64'h099);
    rsp_ready = 1'b1;
    expect_rsp(2, 10'h099);
    drain("split");

    // fairness from reset, requester 1 drops for one cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 32'd0, 32'd2);
    set_req(1, 32'd1, 32'd2);
    set_req(2, 32'd2, 32'd2);
    set_req(3, 32'd3, 32'd2);
    for (int c = 0; c < 13; c++) begin
      req_valid = fair_mask[c];
      #1;
      check("fair_grant", req_ready, 64'd1 << fair_grant[c]);
      check("fair_rsp_valid", rsp_valid, (c >= LAT) ? 64'd1 : 64'd0);
      expect_rsp(fair_grant[c], fair_flags[fair_grant[c]]);
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    drain("fair");

    // backpressure with requesters 0 and 3
    rsp_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 32'd5, 32'd9);
    set_req(3, 32'hFFFF_FFFE, 32'd1);
    req_valid = 4'b1001;
    run_cycles(2);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_ready", req_ready, 64'd0);
      check("bp_valid", rsp_valid, 64'd1);
      check("bp_id", rsp_id, 64'd0);
      check("bp_flags", rsp_flags, 64'h0CC);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    expect_rsp(0, 10'h0CC);
    expect_rsp(3, 10'h099);
    run_cycles(4);
    drain("bp");
    check("bp_all_taken", req_valid, 64'd0);

    // reset with a response pending and another request in flight
    rsp_ready = 1'b0;
    set_req(1, 32'd7, 32'd7);
    set_req(2, 32'd0, 32'hFFFF_FFFF);
    req_valid = 4'b0110;
    run_cycles(3);
    rst = 1'b1;
    #1;
    check("rst_mid_ready", req_ready, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 4'b0110;
    #1;
    check("rst_mid_valid", rsp_valid, 64'd0);
    check("rst_mid_grant", req_ready, 64'h2);
    rsp_ready = 1'b1;
    expect_rsp(1, 10'h0F0);
    expect_rsp(2, 10'h166);
    run_cycles(4);
    drain("rst_mid");

    // counter-vs-threshold sweep against reference comparisons
    for (int n = 0; n < 10000; n++) begin
      rid  = n % 4;
      cnt  = sweep_base[n / 2500] + 32'(n / 64);
      op_a = cnt;
      op_b = (n % 2 == 0) ? cnt - 32'd31 + 32'(n % 64) : cnt - 32'd31 - 32'(n % 64);
      set_req(rid, op_a, op_b);
      req_valid      = '0;
      req_valid[rid] = 1'b1;
      expect_rsp(rid, ref_flags(op_a, op_b));
      tick();
    end
    req_valid = '0;
    drain("sweep");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
